// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the serial frame transmitter, the frame-sync
// receiver and the checker:
//   - mode_e    : transmitter operating modes
//   - state_e   : transmitter FSM states
//   - SYNC_WORD_DEFAULT : default sync byte value
// -----------------------------------------------------------------------------
package frame_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'b00,   // payload from upstream handshake
        MODE_SYNCERR = 2'b01,   // as normal, every 4th sync byte inverted
        MODE_PATTERN = 2'b10,   // payload from internal incrementing counter
        MODE_IDLE    = 2'b11    // no frames, line held low
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'h9B;

endpackage

// File: rtl/frame_shift8.sv
// -----------------------------------------------------------------------------
// frame_shift8
// 8-bit parallel-load shifter, MSB first. Load has priority over shift; a
// shift moves a zero in at the LSB. The MSB is the registered serial output.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears the register)
//   load, din  : parallel load of din
//   shift      : shift left by one
//   msb        : current serial bit (register bit 7)
// -----------------------------------------------------------------------------
module frame_shift8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       msb
);

    logic [7:0] sh_q;
    logic [7:0] sh_d;

    always_comb begin
        // NOTE: default assignment first so every path drives sh_d and no latch is inferred.
        sh_d = sh_q;
        if (load) begin
            sh_d = din;
        end else if (shift) begin
            sh_d = {sh_q[6:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[7];

endmodule

// File: rtl/frame_tx_gen.sv
// -----------------------------------------------------------------------------
// frame_tx_gen
// Serial frame transmitter: one sync byte followed by FRAME_BYTES-1 payload
// bytes, MSB first, one bit per clock, frames back to back. Payload comes
// from an upstream byte handshake or an internal incrementing pattern.
// Parameters:
//   FRAME_BYTES : bytes per frame including sync (2..256)
//   SYNC_WORD   : sync byte value
// Ports:
//   Clock, Reset : clock, synchronous active-low reset
//   Mode         : 00 normal, 01 sync-error injection, 10 pattern, 11 idle
//   TxData/TxValid/TxReady : upstream payload byte handshake
//   DataOut      : serial bit stream
//   FrameStart   : high while DataOut carries bit 7 of the sync byte
//   Underrun     : high on the first bit of a zero filler byte
// All outputs are registered.
// -----------------------------------------------------------------------------
module frame_tx_gen
    import frame_pkg::*;
#(
    parameter int         FRAME_BYTES = 32,
    parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] Mode,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       DataOut,
    output logic       FrameStart,
    output logic       Underrun
);

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    state_e     state_q,       state_d;
    mode_e      mode_q,        mode_d;       // mode latched at the frame boundary
    logic       arm_q,         arm_d;        // first SYNC cycle after IDLE: line still low
    logic [2:0] bit_cnt_q,     bit_cnt_d;    // bit of the current byte on DataOut (0 = MSB)
    logic [7:0] byte_cnt_q,    byte_cnt_d;   // byte of the frame on DataOut (0 = sync)
    logic [1:0] frame_cnt_q,   frame_cnt_d;
    logic [7:0] pat_cnt_q,     pat_cnt_d;
    logic       tx_ready_q,    tx_ready_d;
    logic       frame_start_q, frame_start_d;
    logic       underrun_q,    underrun_d;

    logic       boundary;
    logic       sh_load;
    logic       sh_shift;
    logic [7:0] sh_din;

    frame_shift8 u_shift (
        .clk   (Clock),
        .rst_n (Reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (DataOut)
    );

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        arm_d         = arm_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        pat_cnt_d     = pat_cnt_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        boundary      = 1'b0;
        sh_load       = 1'b0;
        sh_shift      = 1'b0;
        sh_din        = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                // Keep the line low while idle.
                sh_load = 1'b1;
                if (mode_e'(Mode) != MODE_IDLE) begin
                    state_d = ST_SYNC;
                    arm_d   = 1'b1;
                end
            end
            ST_SYNC, ST_PAYLOAD: begin
                if (arm_q) begin
                    boundary = 1'b1;
                end else if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        boundary = 1'b1;
                    end else begin
                        // Last bit of a byte that is followed by payload: load next byte.
                        sh_load    = 1'b1;
                        state_d    = ST_PAYLOAD;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (mode_q == MODE_PATTERN) begin
                            sh_din    = pat_cnt_q;
                            pat_cnt_d = pat_cnt_q + 8'd1;
                        end else if (TxValid && tx_ready_q) begin
                            sh_din = TxData;
                        end else begin
                            underrun_d = 1'b1;   // filler 8'h00 already on sh_din
                        end
                    end
                end else begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame boundary: the only place Mode is latched for a frame.
        if (boundary) begin
            arm_d      = 1'b0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            sh_load    = 1'b1;
            if (mode_e'(Mode) == MODE_IDLE) begin
                state_d = ST_IDLE;
                sh_din  = 8'h00;
            end else begin
                state_d       = ST_SYNC;
                mode_d        = mode_e'(Mode);
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 2'd1;
                if (mode_e'(Mode) == MODE_SYNCERR && frame_cnt_q == 2'd3) begin
                    sh_din = ~SYNC_WORD;
                end else begin
                    sh_din = SYNC_WORD;
                end
            end
        end

        // Registered ready: asserted for the cycle that will carry bit 0 of a
        // byte followed by a payload byte, only when payload comes from upstream.
        tx_ready_d = (state_d != ST_IDLE) && !arm_d && (bit_cnt_d == 3'd7) &&
                     (byte_cnt_d != LAST_BYTE) && (mode_d != MODE_PATTERN);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_NORMAL;
            arm_q         <= 1'b0;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 8'd0;
            frame_cnt_q   <= 2'd0;
            pat_cnt_q     <= 8'd0;
            tx_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            arm_q         <= arm_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            pat_cnt_q     <= pat_cnt_d;
            tx_ready_q    <= tx_ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign TxReady    = tx_ready_q;
    assign FrameStart = frame_start_q;
    assign Underrun   = underrun_q;

endmodule

// File: tb/tb_frame_tx_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_tx_gen
// Self-checking bench for frame_tx_gen. Expected bytes are pushed to a
// scoreboard queue as stimulus is set up and popped as the DUT serialises
// each byte. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_frame_tx_gen;

    localparam int         FB = 32;
    localparam logic [7:0] SW = 8'h9B;

    logic       Clock   = 1'b0;
    logic       Reset   = 1'b0;
    logic [1:0] Mode    = 2'b00;
    logic [7:0] TxData  = 8'h00;
    logic       TxValid = 1'b0;
    logic       TxReady;
    logic       DataOut;
    logic       FrameStart;
    logic       Underrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       fs_first;
        int         fs_cnt;
        logic       ur_first;
        int         ur_cnt;
        int         rdy_cnt;
        logic       rdy_last;
        int         cyc0;
    } cap_t;

    cap_t cb;

    frame_tx_gen #(
        .FRAME_BYTES (FB),
        .SYNC_WORD   (SW)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Mode       (Mode),
        .TxData     (TxData),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .DataOut    (DataOut),
        .FrameStart (FrameStart),
        .Underrun   (Underrun)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Samples the current cycle and the following seven, leaving the bench
    // on the first cycle of the next byte.
    task automatic cap_byte();
        cb.data = 8'h00; cb.fs_cnt = 0; cb.ur_cnt = 0; cb.rdy_cnt = 0;
        cb.fs_first = FrameStart; cb.ur_first = Underrun; cb.rdy_last = 1'b0;
        cb.cyc0 = cyc;
        for (int i = 0; i < 8; i++) begin
            cb.data = {cb.data[6:0], DataOut};
            if (FrameStart === 1'b1) cb.fs_cnt++;
            if (Underrun === 1'b1) cb.ur_cnt++;
            if (TxReady === 1'b1) cb.rdy_cnt++;
            if (i == 7) cb.rdy_last = TxReady;
            tick();
        end
    endtask

    task automatic wait_fs(input int budget, input string tag);
        int n;
        n = 0;
        while (FrameStart !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (FrameStart !== 1'b1) begin
            failures++;
            $display("FAIL %s_fs_timeout got=none exp=FrameStart within %0d cycles", tag, budget);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Mode = 2'b00; TxValid = 1'b1; TxData = 8'hA5; Reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({DataOut, FrameStart, TxReady, Underrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {DataOut, FrameStart, TxReady, Underrun});
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (FrameStart !== 1'b0 || DataOut !== 1'b0) begin
            failures++;
            $display("FAIL release_cycle1 got=fs%b do%b exp=fs0 do0", FrameStart, DataOut);
        end
        tick();
        checks++;
        if (FrameStart !== 1'b1) begin
            failures++;
            $display("FAIL release_cycle2_fs got=%b exp=1", FrameStart);
        end
    endtask

    // Continues from test_reset, aligned on the first sync bit.
    task automatic test_normal();
        int rdy, fs, t0;
        logic [7:0] e;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(SW);
            for (int k = 1; k < FB; k++) exp_q.push_back(8'hA5);
        end
        t0 = cyc;
        for (int f = 0; f < 2; f++) begin
            rdy = 0; fs = 0;
            for (int k = 0; k < FB; k++) begin
                cap_byte();
                e = exp_q.pop_front();
                checks++;
                if (cb.data !== e) begin
                    failures++;
                    $display("FAIL normal_byte f%0d b%0d got=%h exp=%h", f, k, cb.data, e);
                end
                if (k == 0) begin
                    checks++;
                    if (cb.fs_first !== 1'b1) begin
                        failures++;
                        $display("FAIL normal_fs_first f%0d got=%b exp=1", f, cb.fs_first);
                    end
                end
                if (k == FB - 1) begin
                    checks++;
                    if (cb.rdy_cnt != 0) begin
                        failures++;
                        $display("FAIL normal_last_byte_ready f%0d got=%0d exp=0", f, cb.rdy_cnt);
                    end
                end
                rdy += cb.rdy_cnt;
                fs  += cb.fs_cnt;
            end
            checks++;
            if (rdy != FB - 1) begin
                failures++;
                $display("FAIL normal_ready_count f%0d got=%0d exp=%0d", f, rdy, FB - 1);
            end
            checks++;
            if (fs != 1) begin
                failures++;
                $display("FAIL normal_fs_count f%0d got=%0d exp=1", f, fs);
            end
        end
        checks++;
        if (FrameStart !== 1'b1 || cyc - t0 != 2 * FB * 8) begin
            failures++;
            $display("FAIL normal_period got=fs%b after %0d exp=fs1 after %0d", FrameStart, cyc - t0, 2 * FB * 8);
        end
    endtask

    task automatic test_syncerr();
        int prev;
        logic [7:0] e;
        Mode = 2'b01; TxValid = 1'b1; TxData = 8'h3C;
        do_reset();
        wait_fs(8, "syncerr");
        for (int f = 0; f < 8; f++) begin
            exp_q.push_back((f % 4 == 3) ? ~SW : SW);
            for (int k = 1; k < FB; k++) exp_q.push_back(8'h3C);
        end
        prev = 0;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < FB; k++) begin
                cap_byte();
                e = exp_q.pop_front();
                checks++;
                if (cb.data !== e) begin
                    failures++;
                    $display("FAIL syncerr_byte f%0d b%0d got=%h exp=%h", f, k, cb.data, e);
                end
                if (k == 0) begin
                    checks++;
                    if (cb.fs_first !== 1'b1 || (f > 0 && cb.cyc0 - prev != FB * 8)) begin
                        failures++;
                        $display("FAIL syncerr_period f%0d got=fs%b period %0d exp=fs1 period %0d",
                                 f, cb.fs_first, cb.cyc0 - prev, FB * 8);
                    end
                    prev = cb.cyc0;
                end
            end
        end
    endtask

    task automatic test_pattern();
        int rdy;
        logic [7:0] p, e;
        Mode = 2'b10; TxValid = 1'b1; TxData = 8'hEE;
        do_reset();
        wait_fs(8, "pattern");
        p = 8'h00;
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(SW);
            for (int k = 1; k < FB; k++) begin
                exp_q.push_back(p);
                p = p + 8'd1;
            end
        end
        rdy = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FB; k++) begin
                cap_byte();
                e = exp_q.pop_front();
                checks++;
                if (cb.data !== e) begin
                    failures++;
                    $display("FAIL pattern_byte f%0d b%0d got=%h exp=%h", f, k, cb.data, e);
                end
                rdy += cb.rdy_cnt;
            end
        end
        checks++;
        if (rdy != 0) begin
            failures++;
            $display("FAIL pattern_ready got=%0d exp=0", rdy);
        end
    endtask

    task automatic test_underrun();
        int ur;
        logic [7:0] e;
        Mode = 2'b00; TxValid = 1'b1; TxData = 8'h11;
        do_reset();
        wait_fs(8, "underrun");
        exp_q.push_back(SW);
        for (int k = 1; k < FB; k++) exp_q.push_back((k == 5) ? 8'h00 : 8'(8'h10 + k));
        ur = 0;
        for (int k = 0; k < FB; k++) begin
            // Byte k+1 is accepted at the edge that ends byte k.
            TxData  = 8'(8'h10 + k + 1);
            TxValid = (k + 1 != 5);
            cap_byte();
            e = exp_q.pop_front();
            checks++;
            if (cb.data !== e) begin
                failures++;
                $display("FAIL underrun_byte b%0d got=%h exp=%h", k, cb.data, e);
            end
            if (k == 5) begin
                checks++;
                if (cb.ur_first !== 1'b1 || cb.ur_cnt != 1) begin
                    failures++;
                    $display("FAIL underrun_pulse got=first%b cnt%0d exp=first1 cnt1", cb.ur_first, cb.ur_cnt);
                end
            end
            ur += cb.ur_cnt;
        end
        TxValid = 1'b1;
        checks++;
        if (ur != 1) begin
            failures++;
            $display("FAIL underrun_total got=%0d exp=1", ur);
        end
    endtask

    task automatic test_idle();
        int bad;
        logic [7:0] e;
        Mode = 2'b00; TxValid = 1'b1; TxData = 8'h5A;
        do_reset();
        wait_fs(8, "idle");
        exp_q.push_back(SW);
        for (int k = 1; k < FB; k++) exp_q.push_back(8'h5A);
        for (int k = 0; k < FB; k++) begin
            if (k == 13) Mode = 2'b11;   // mid-frame: current frame must complete
            cap_byte();
            e = exp_q.pop_front();
            checks++;
            if (cb.data !== e) begin
                failures++;
                $display("FAIL idle_frame_byte b%0d got=%h exp=%h", k, cb.data, e);
            end
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({DataOut, FrameStart, TxReady, Underrun} !== 4'b0000) bad++;
            if (i < 19) tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet got=%0d active cycles exp=0", bad);
        end
        Mode = 2'b00;
        tick();
        checks++;
        if (FrameStart !== 1'b0 || DataOut !== 1'b0) begin
            failures++;
            $display("FAIL idle_exit_cycle1 got=fs%b do%b exp=fs0 do0", FrameStart, DataOut);
        end
        tick();
        checks++;
        if (FrameStart !== 1'b1) begin
            failures++;
            $display("FAIL idle_exit_cycle2_fs got=%b exp=1", FrameStart);
        end
        exp_q.push_back(SW);
        cap_byte();
        e = exp_q.pop_front();
        checks++;
        if (cb.data !== e) begin
            failures++;
            $display("FAIL idle_exit_sync got=%h exp=%h", cb.data, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        Mode = 2'b01; TxValid = 1'b1; TxData = 8'h77;
        do_reset();
        wait_fs(8, "reset_mid");
        // Frames 0 and 1, plus the sync of frame 2; FrameCnt is then 3.
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back(SW);
            for (int k = 1; k < FB; k++) exp_q.push_back(8'h77);
        end
        exp_q.push_back(SW);
        for (int n = 0; n < 2 * FB + 1; n++) begin
            cap_byte();
            e = exp_q.pop_front();
            checks++;
            if (cb.data !== e) begin
                failures++;
                $display("FAIL reset_mid_pre_byte n%0d got=%h exp=%h", n, cb.data, e);
            end
        end
        for (int i = 0; i < 60; i++) tick();
        Reset = 1'b0;
        tick();
        checks++;
        if ({DataOut, FrameStart, TxReady, Underrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b exp=0000", {DataOut, FrameStart, TxReady, Underrun});
        end
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (FrameStart !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart_fs got=%b exp=1", FrameStart);
        end
        // Counter restarted: frames 0..2 normal sync, frame 3 inverted.
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(SW);
            for (int k = 1; k < FB; k++) exp_q.push_back(8'h77);
        end
        exp_q.push_back(~SW);
        for (int n = 0; n < 3 * FB + 1; n++) begin
            cap_byte();
            e = exp_q.pop_front();
            checks++;
            if (cb.data !== e) begin
                failures++;
                $display("FAIL reset_mid_post_byte n%0d got=%h exp=%h", n, cb.data, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_syncerr();
        test_pattern();
        test_underrun();
        test_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_tx_gen.md
# frame_tx_gen

Serial frame transmitter feeding the frame-synchronisation receiver. It builds fixed-length frames: one sync byte followed by FRAME_BYTES-1 payload bytes. Each byte is sent MSB first, one bit per Clock. Payload comes from an upstream byte handshake or from an internal test pattern. Mode selects normal traffic, sync-error injection, self-test pattern, or idle, so the receiver's lock, loss-of-lock and data-check paths can be exercised from one source.

## Interface
Parameters:
- FRAME_BYTES, 32: bytes per frame including the sync byte; legal range 2..256.
- SYNC_WORD, 8'h9B: sync byte value.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Mode  in  2  00 normal, 01 sync-error injection, 10 self-test pattern, 11 idle.
- TxData  in  8  upstream payload byte.
- TxValid  in  1  TxData valid.
- TxReady  out  1  transmitter takes a payload byte this cycle.
- DataOut  out  1  serial frame bit stream.
- FrameStart  out  1  high while DataOut carries bit 7 of the sync byte.
- Underrun  out  1  one-cycle pulse: a filler byte is being sent.

## Operation
- Reset (Reset==0 at a rising edge) clears everything:
  - DataOut, FrameStart, TxReady and Underrun go to 0.
  - Bit counter, byte counter, 2-bit FrameCnt and 8-bit PatCnt go to 0.
  - State goes to IDLE.
  - Reset has priority over all other activity and aborts a frame mid-stream; no partial-frame completion.
- States: IDLE, SYNC, PAYLOAD.
  - IDLE: DataOut=0. Mode is checked every cycle. Mode!=11 → SYNC at the next edge.
  - SYNC: 8 cycles, shifting out the sync byte, then → PAYLOAD.
  - PAYLOAD: (FRAME_BYTES-1)×8 cycles. At the last bit, Mode is sampled: Mode==11 → IDLE, otherwise → SYNC. Frames are back-to-back with no gap.
- Mode is sampled only at frame boundaries, i.e. on the edge that would load the sync byte. A Mode change mid-frame takes effect at the next frame.
- Sync byte value: SYNC_WORD. Exception: when the latched mode is 01 and FrameCnt==3, send ~SYNC_WORD.
- FrameCnt increments (mod 4) on every frame start.
- Payload source:
  - Modes 00 and 01: TxData via handshake.
  - Mode 10: PatCnt, which increments (mod 256) after each payload byte and continues across frames. TxReady stays 0 in this mode.
- Handshake (modes 00/01):
  - TxReady is high during the cycle in which DataOut carries bit 0 of a byte that is followed by a payload byte. This covers the last bit of the sync byte and of payload bytes 1..FRAME_BYTES-2.
  - Transfer happens when TxValid && TxReady at that edge. The byte is loaded into the shifter and its bit 7 appears on DataOut the next cycle.
  - TxValid==0 at that edge: load 8'h00 filler and pulse Underrun for that byte's first bit cycle. TxData is ignored.
  - TxData is not buffered beyond the single accepted byte.

## Timing
- First rising edge with Reset==1 and Mode!=11: state IDLE → SYNC. On the following edge, DataOut=SYNC_WORD[7] and FrameStart=1.
- Frame period: FRAME_BYTES×8 cycles. FrameStart is high for exactly 1 cycle per frame.
- TxReady-to-DataOut latency: byte bit 7 appears 1 cycle after the accepting edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Mode==11 sampled at a boundary: DataOut=0 from the cycle where the sync bit 7 would have been sent. Leaving IDLE takes 2 cycles to the first sync bit.
- Reset asserted mid-frame: DataOut=0 on the next edge; restart per the first rule.

## Structure
- Shared package frame_pkg holds:
  - mode encodings MODE_NORMAL, MODE_SYNCERR, MODE_PATTERN, MODE_IDLE;
  - the state encoding for IDLE, SYNC and PAYLOAD;
  - the default SYNC_WORD (8'h9B), shared with the receiver and checker.
- One sub-module: frame_shift8, an 8-bit parallel-load, MSB-first shifter with load/shift enables. The FSM, counters and handshake live in frame_tx_gen.

## Test plan
- Reset low 2 cycles, Mode=00, TxValid=1, TxData=8'hA5 held → first FrameStart on the 2nd cycle after release; first 8 bits 10011011; then 31×8'hA5; 32 TxReady pulses never occur, exactly 31 per frame.
- Mode=01, 8 frames → frames 3 and 7 carry 8'h64; the rest carry 8'h9B; FrameStart period is 256 cycles.
- Mode=10, 2 frames → payload bytes 0x00..0x1E in frame 0, 0x1F..0x3D in frame 1; TxReady never high.
- Mode=00, TxValid dropped for byte 5 of frame 0 → byte 5 = 8'h00; Underrun pulses once at that byte's bit 7 cycle; neighbouring bytes intact.
- Mode switched 00→11 at payload bit 100 → current frame completes; DataOut=0 afterwards; Mode=00 restores FrameStart 2 cycles later.
- Reset pulsed low at payload bit 60 → all outputs 0 next cycle; FrameCnt restarts at 0, so the first frame after release carries the normal sync in Mode=01.
